// File: rtl/irq_service_ctrl.sv
// irq_service_ctrl: picks the highest-priority enabled pending interrupt,
// waits for an instruction boundary, captures EPC, redirects the CPU to the
// source's handler vector, pulses a clear to that source, and blocks nesting
// until ERET.
module irq_service_ctrl #(
    parameter int unsigned N_SRC      = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_pending,
    output logic [N_SRC-1:0] irq_clear,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    output logic [N_SRC-1:0] irq_mask,
    input  logic             instr_boundary,
    input  logic [31:0]      pc_cur,
    input  logic             eret,
    output logic             int_take,
    output logic [31:0]      int_vector,
    output logic [31:0]      epc,
    output logic             in_service,
    output logic [2:0]       active_id
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAKE    = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [N_SRC-1:0] eligible;
    logic [2:0]       winner;
    logic             found;
    logic             decide;

    // Fixed-priority pick of the lowest enabled pending source.
    always_comb begin
        eligible = irq_pending & irq_mask;
        winner   = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (eligible[i] && !found) begin
                winner = 3'(i);
                found  = 1'b1;
            end
        end
        decide = (state == IDLE) && instr_boundary && found;
    end

    // Next-state logic for the service sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (decide) state_nxt = TAKE;
            TAKE:    state_nxt = SERVICE;
            SERVICE: if (eret) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Mask register and capture of source, return address and vector at the decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_mask   <= '1;
            active_id  <= '0;
            epc        <= '0;
            int_vector <= VEC_BASE;
        end else begin
            if (mask_we) begin
                irq_mask <= mask_wdata;
            end
            if (decide) begin
                active_id  <= winner;
                epc        <= pc_cur;
                int_vector <= VEC_BASE + VEC_STRIDE * {29'd0, winner};
            end
        end
    end

    // Outputs decode from registered state only, so none depend on inputs directly.
    always_comb begin
        int_take   = (state == TAKE);
        in_service = (state == SERVICE);
        irq_clear  = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            irq_clear[i] = (state == TAKE) && (active_id == 3'(i));
        end
    end

endmodule
